// File: rtl/interp_rate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : interp_rate_ctrl_if
// Description : Configuration handshake bundle for the interpolator rate
//               controller. It carries the target step and slew limit with a
//               valid/ready pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface interp_rate_ctrl_if #(
    parameter int CTRBITS  = 32,
    parameter int SLEWBITS = 16
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CTRBITS-1:0]  cfg_step;
    logic [SLEWBITS-1:0] cfg_slew;

    // Side that offers a new configuration
    modport master (
        output cfg_valid,
        output cfg_step,
        output cfg_slew,
        input  cfg_ready
    );

    // Side that accepts a configuration (the rate controller)
    modport slave (
        input  cfg_valid,
        input  cfg_step,
        input  cfg_slew,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/interp_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interp_rate_ctrl
// Description : Slew-limited phase-step controller for the nearest-neighbour
//               interpolator. It moves the live step toward the configured
//               target by at most r_slew per accepted input sample. It also
//               re-times the sample strobe so that every o_ce pulse carries
//               the step computed for that sample.
// Revision    : 1.0 - initial release
// ============================================================================
module interp_rate_ctrl #(
    parameter int CTRBITS  = 32,
    parameter int SLEWBITS = 16
) (
    input  wire logic               i_clk,
    input  wire logic               i_areset_n,
    input  wire logic               i_enable,
    input  wire logic               i_ce,
    interp_rate_ctrl_if.slave       cfg,
    output logic                    o_ce,
    output logic [CTRBITS-1:0]      o_step,
    output logic                    o_locked
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CTRBITS-1:0]  r_step;
    logic [CTRBITS-1:0]  r_target;
    logic [SLEWBITS-1:0] r_slew;
    logic                r_ce;
    logic                r_locked;
    logic                r_cfg_ready;

    logic                w_accept;
    logic                w_up;
    logic [CTRBITS-1:0]  w_slew_ext;
    logic [CTRBITS-1:0]  w_dist;
    logic                w_clamp;
    state_t              w_next_state;
    logic [CTRBITS-1:0]  w_next_step;

    // The ready output is a registered copy of (state != RAMP). Because of
    // that, a retarget cannot land in the middle of a ramp.
    assign w_accept      = cfg.cfg_valid & r_cfg_ready;
    assign cfg.cfg_ready = r_cfg_ready;
    assign o_ce          = r_ce;
    assign o_step        = r_step;
    assign o_locked      = r_locked;

    // Distance to the target and the clamp decision. The clamp means the
    // modulo arithmetic can never step past or wrap around the target.
    always_comb begin
        w_slew_ext = CTRBITS'(r_slew);
        w_up       = (r_target > r_step);
        w_dist     = w_up ? (r_target - r_step) : (r_step - r_target);
        w_clamp    = (r_slew == '0) || (w_dist <= w_slew_ext);
    end

    // Next-state and next-step selection
    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        if (!i_enable) begin
            // Disabled: freeze the step and park the FSM in IDLE. A partial
            // ramp resumes from the frozen step once the block is re-enabled.
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A config taken here only loads the registers. The
                    // target compare happens on the following cycle.
                    if (!w_accept) begin
                        w_next_state = (r_step == r_target) ? ST_RUN : ST_RAMP;
                    end
                end
                ST_RUN: begin
                    if (w_accept && (cfg.cfg_step != r_step)) begin
                        w_next_state = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (i_ce) begin
                        if (w_clamp) begin
                            w_next_step  = r_target;
                            w_next_state = ST_RUN;
                        end else if (w_up) begin
                            w_next_step  = r_step + w_slew_ext;
                        end else begin
                            w_next_step  = r_step - w_slew_ext;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State, configuration and registered outputs
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state     <= ST_IDLE;
            r_step      <= '0;
            r_target    <= '0;
            r_slew      <= '0;
            r_ce        <= 1'b0;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_step      <= w_next_step;
            if (w_accept) begin
                r_target <= cfg.cfg_step;
                r_slew   <= cfg.cfg_slew;
            end
            r_ce        <= i_ce & i_enable & (r_state != ST_IDLE);
            r_locked    <= i_enable &
                           ((r_state == ST_RUN) || (w_next_state == ST_RUN));
            r_cfg_ready <= (w_next_state != ST_RAMP);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interp_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interp_rate_ctrl
// Description : Scoreboard bench for interp_rate_ctrl. The stimulus pushes
//               the expected step for every sample that should produce an
//               o_ce pulse. A negedge monitor pops the queue on each o_ce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interp_rate_ctrl;

    localparam int CTRBITS  = 32;
    localparam int SLEWBITS = 16;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               ce_in;
    logic               ce_out;
    logic [CTRBITS-1:0] step_out;
    logic               locked;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    interp_rate_ctrl_if #(.CTRBITS(CTRBITS), .SLEWBITS(SLEWBITS)) cfg_if ();

    interp_rate_ctrl #(.CTRBITS(CTRBITS), .SLEWBITS(SLEWBITS)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .i_enable   (enable),
        .i_ce       (ce_in),
        .cfg        (cfg_if),
        .o_ce       (ce_out),
        .o_step     (step_out),
        .o_locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge(s)
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One sample strobe. The expected step is queued when this sample must
    // reach the interpolator.
    task automatic ce_cycle(input bit expect_out, input logic [31:0] exp_step);
        ce_in = 1'b1;
        if (expect_out) exp_q.push_back(exp_step);
        tick(1);
        ce_in = 1'b0;
    endtask

    // Offer a configuration and hold it until accepted, with a bounded wait
    task automatic cfg_send(input logic [31:0] stp, input logic [15:0] slw);
        bit done;
        done = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_step  = stp;
        cfg_if.cfg_slew  = slw;
        for (int i = 0; i < 20 && !done; i++) begin
            if (cfg_if.cfg_ready) done = 1'b1;
            tick(1);
        end
        cfg_if.cfg_valid = 1'b0;
        if (!done) chk("cfg_accept_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: every o_ce must match a queued expectation
    always @(negedge clk) begin
        if (ce_out) begin
            if (exp_q.size() == 0) begin
                chk("ce_unexpected", 32'd1, 32'd0);
            end else begin
                chk("step_on_ce", step_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b0;
        ce_in            = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_step  = '0;
        cfg_if.cfg_slew  = '0;
        tick(3);

        // Reset values
        chk("rst_step",   step_out, 32'h0);
        chk("rst_ce",     {31'd0, ce_out}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_ready",  {31'd0, cfg_if.cfg_ready}, 32'd1);
        rst_n = 1'b1;
        tick(1);

        // Enable without config: step 0, o_ce 1 cycle after each i_ce
        enable = 1'b1;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            ce_cycle(1'b1, 32'h0);
            tick(3);
        end
        chk("t1_locked", {31'd0, locked}, 32'd1);
        chk("t1_ready",  {31'd0, cfg_if.cfg_ready}, 32'd1);

        // Jump to 0x1000 with slew 0
        cfg_send(32'h1000, 16'h0);
        ce_cycle(1'b1, 32'h1000);

        // Upward ramp 0x1000 -> 0x1400, slew 0x100, i_ce every cycle.
        // The sample in the accept cycle still carries the old step.
        chk("t2_ready_pre", {31'd0, cfg_if.cfg_ready}, 32'd1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_step  = 32'h1400;
        cfg_if.cfg_slew  = 16'h100;
        ce_in = 1'b1;
        exp_q.push_back(32'h1000);
        tick(1);
        cfg_if.cfg_valid = 1'b0;
        chk("t2_ready_ramp", {31'd0, cfg_if.cfg_ready}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(32'h1000 + 32'(k) * 32'h100);
            tick(1);
            chk("t2_ready", {31'd0, cfg_if.cfg_ready}, (k == 4) ? 32'd1 : 32'd0);
            chk("t2_locked", {31'd0, locked}, (k == 4) ? 32'd1 : 32'd0);
        end
        ce_in = 1'b0;
        tick(2);

        // Downward ramp with clamp: 0x1000 -> 0x0F50, slew 0x40
        cfg_send(32'h1000, 16'h0);
        ce_cycle(1'b1, 32'h1000);
        cfg_send(32'h0F50, 16'h40);
        ce_cycle(1'b1, 32'h0FC0);
        chk("t3_locked_mid", {31'd0, locked}, 32'd0);
        ce_cycle(1'b1, 32'h0F80);
        ce_cycle(1'b1, 32'h0F50);
        chk("t3_locked", {31'd0, locked}, 32'd1);
        chk("t3_ready",  {31'd0, cfg_if.cfg_ready}, 32'd1);

        // slew 0 jump across most of the range: 0x10 -> 0xFFFF0000
        cfg_send(32'h10, 16'h0);
        ce_cycle(1'b1, 32'h10);
        cfg_send(32'hFFFF_0000, 16'h0);
        ce_cycle(1'b1, 32'hFFFF_0000);
        chk("t4_locked", {31'd0, locked}, 32'd1);
        tick(2);
        chk("t4_hold", step_out, 32'hFFFF_0000);

        // Drop enable mid-ramp at 0x1200, then resume
        cfg_send(32'h1000, 16'h0);
        ce_cycle(1'b1, 32'h1000);
        cfg_send(32'h1400, 16'h100);
        ce_cycle(1'b1, 32'h1100);
        ce_cycle(1'b1, 32'h1200);
        enable = 1'b0;
        ce_in  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("t5_ce_off",  {31'd0, ce_out}, 32'd0);
            chk("t5_frozen",  step_out, 32'h1200);
        end
        chk("t5_locked_off", {31'd0, locked}, 32'd0);
        enable = 1'b1;
        tick(1);
        chk("t5_first_ce", {31'd0, ce_out}, 32'd0);
        exp_q.push_back(32'h1300);
        tick(1);
        exp_q.push_back(32'h1400);
        tick(1);
        ce_in = 1'b0;
        chk("t5_locked", {31'd0, locked}, 32'd1);
        tick(2);

        // Config offered during RAMP must be ignored
        cfg_send(32'h2000, 16'h100);
        ce_cycle(1'b1, 32'h1500);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_step  = 32'h3000;
        cfg_if.cfg_slew  = 16'h0;
        for (int k = 0; k < 3; k++) begin
            chk("t6_ready_ramp", {31'd0, cfg_if.cfg_ready}, 32'd0);
            tick(1);
        end
        cfg_if.cfg_valid = 1'b0;
        ce_cycle(1'b1, 32'h1600);

        // Asynchronous reset mid-ramp, with an o_ce pulse in flight
        ce_in = 1'b1;
        tick(1);
        ce_in = 1'b0;
        chk("t6_ce_pre",   {31'd0, ce_out}, 32'd1);
        chk("t6_step_pre", step_out, 32'h1700);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_step",   step_out, 32'h0);
        chk("t6_rst_ce",     {31'd0, ce_out}, 32'd0);
        chk("t6_rst_ready",  {31'd0, cfg_if.cfg_ready}, 32'd1);
        chk("t6_rst_locked", {31'd0, locked}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        ce_cycle(1'b1, 32'h0);
        chk("t6_post_locked", {31'd0, locked}, 32'd1);

        tick(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interp_rate_ctrl.md
# interp_rate_ctrl

Rate controller for the nearest-neighbor interpolator. It accepts a target phase step over a valid/ready configuration handshake and moves the live step toward that target by at most a programmed slew per input sample, so the output rate never jumps abruptly. It gates and re-times the input sample strobe so the interpolator always sees a step value aligned with its clock enable. It sits between the register/control interface and the interpolator's step and clock-enable inputs.

## Interface
- CTRBITS, 32: width of the phase step and of the interpolator's counter.
- SLEWBITS, 16: width of the per-sample slew limit; zero-extended to CTRBITS.
- i_clk  input  1  system clock; all logic on the rising edge.
- i_areset_n  input  1  reset, asynchronous and active-low.
- i_enable  input  1  level; low gates the output strobe and freezes the ramp.
- i_ce  input  1  input sample strobe.
- i_cfg_valid  input  1  new configuration offered.
- o_cfg_ready  output  1  configuration can be accepted this cycle.
- i_cfg_step  input  CTRBITS  target step.
- i_cfg_slew  input  SLEWBITS  maximum step change per sample; 0 means jump immediately.
- o_ce  output  1  registered, gated strobe to the interpolator's clock enable.
- o_step  output  CTRBITS  registered live step to the interpolator's step input.
- o_locked  output  1  high when o_step equals the target and the block is enabled.

## Operation
- Internal registers: r_target (CTRBITS), r_slew (SLEWBITS), state in {IDLE, RAMP, RUN}.
- Reset values: state=IDLE, o_step=0, r_target=0, r_slew=0, o_ce=0, o_locked=0, o_cfg_ready=1.
- Handshake: a configuration is accepted when i_cfg_valid and o_cfg_ready are both high. On acceptance, r_target and r_slew load the new values.
- o_cfg_ready is high in IDLE and RUN and low in RAMP. A retarget is never taken in the middle of a ramp.
- IDLE: o_ce=0 and o_step holds its value.
  - Leave IDLE when i_enable=1: go to RUN if o_step==r_target, otherwise RAMP.
  - A configuration accepted in IDLE only loads the registers; the state is re-evaluated on the next cycle.
- RUN:
  - Accepting a configuration with i_cfg_step != o_step moves the state to RAMP.
  - Accepting a configuration with i_cfg_step == o_step stays in RUN.
- RAMP: on each cycle with i_ce=1 and i_enable=1, update o_step:
  - With d = |r_target - o_step| (unsigned compare): if r_slew==0 or d <= r_slew, then o_step <= r_target and the state goes to RUN.
  - Otherwise, o_step <= o_step + r_slew when the target is above, or o_step - r_slew when it is below.
  - Step arithmetic is unsigned modulo 2^CTRBITS. Because the block clamps to the target, it never wraps past it.
- Any state with i_enable=0: go to IDLE on the next edge. o_step and r_target are frozen. A partial ramp resumes from the frozen o_step when re-enabled.
- o_ce <= i_ce & i_enable & (state != IDLE), registered.
- o_locked <= (state==RUN) or (next state is RUN), registered, and also requires i_enable.

## Timing
- o_ce lags i_ce by exactly 1 cycle.
- o_step updates on the same edge that raises the corresponding o_ce, so every o_ce pulse carries the step computed for that sample.
- Config accepted on cycle N while in RUN:
  - If i_ce=1 on cycle N, that sample still uses the old step.
  - The first ramp update happens on the first i_ce cycle after N.
- Re-enable: i_enable rising at cycle N gives state≠IDLE at N+1. The first o_ce possible is at N+2, from an i_ce at N+1.
- Reset asserted mid-ramp: all outputs return to their reset values immediately (asynchronous). Deassertion takes effect on the following edge.
- A back-to-back i_ce every cycle is supported: one ramp step per cycle.

## Test plan
- Reset, enable, then apply i_ce at 1 in 4 cycles with no configuration: o_step=0, o_ce pulses 1 cycle after each i_ce, o_locked=1.
- In RUN at step 0x1000, send config step=0x1400, slew=0x100 with i_ce every cycle: o_step reads 0x1100, 0x1200, 0x1300, 0x1400 on successive o_ce. o_cfg_ready is low for those 4 samples, then high; o_locked rises with 0x1400.
- Downward ramp with non-multiple distance: step 0x1000→0x0F50, slew=0x40: o_step reads 0x0FC0, 0x0F80, 0x0F50 (clamped), then RUN.
- slew=0 configuration to step 0xFFFF0000 from 0x10: o_step=0xFFFF0000 on the next sampled i_ce, with no wrap artifacts.
- Drop i_enable mid-ramp at step 0x1200 (target 0x1400) for 10 cycles with i_ce active: o_ce=0 and o_step frozen at 0x1200. After re-enable, the ramp resumes: 0x1300, 0x1400.
- Assert i_areset_n low during RAMP: o_step=0, o_ce=0, o_cfg_ready=1 in the same cycle. A config offered with i_cfg_valid=1 while o_cfg_ready=0 (RAMP) is not accepted.
